lif_neuron_layer: RTL and testbench

LIF_NEURON_LAYER -- requirements
Module: lif_neuron_layer

---
 rtl/lif_neuron_layer.sv | 145 ++++++++++++++
 tb/tb_lif_neuron_layer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_layer.sv
// Layer of leaky integrate-and-fire neurons over a byte-serial binary input vector.
// Neurons are evaluated one per cycle against a shared input vector and per-neuron weight masks.
module lif_neuron_layer #(
   parameter int N_NEURONS = 4,
   parameter int INPUTS    = 32,
   parameter int U_BITS    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [7:0]                  in_data,
   output logic                        in_ready,
   input  logic                        cfg_w_we,
   input  logic [7:0]                  cfg_w_data,
   input  logic [2:0]                  cfg_shift,
   input  logic signed [U_BITS-1:0]    cfg_theta,
   output logic                        out_valid,
   output logic [N_NEURONS-1:0]        out_spikes,
   input  logic                        out_ready
);

   localparam int IN_BYTES = INPUTS / 8;
   localparam int W_BITS   = N_NEURONS * INPUTS;
   localparam int W_BYTES  = W_BITS / 8;
   localparam int CNT_W    = $clog2(IN_BYTES > 1 ? IN_BYTES : 2);
   localparam int PTR_W    = $clog2(W_BYTES > 1 ? W_BYTES : 2);
   localparam int IDX_W    = $clog2(N_NEURONS > 1 ? N_NEURONS : 2);
   localparam int EXT_W    = U_BITS + 2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_BYTES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(W_BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);
   localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'((2 ** (U_BITS - 1)) - 1);
   localparam logic signed [EXT_W-1:0] U_MIN = -(EXT_W'(2 ** (U_BITS - 1)));

   typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

   state_t                     state;
   logic [CNT_W-1:0]           cnt;
   logic [PTR_W-1:0]           wptr;
   logic [IDX_W-1:0]           idx;
   logic [INPUTS-1:0]          x;
   logic [W_BITS-1:0]          w;
   logic signed [U_BITS-1:0]   u [N_NEURONS];
   logic [N_NEURONS-1:0]       was_spike;

   function automatic logic signed [U_BITS-1:0] sat_u(input logic signed [EXT_W-1:0] v);
      if (v > U_MAX)      return U_MAX[U_BITS-1:0];
      else if (v < U_MIN) return U_MIN[U_BITS-1:0];
      else                return v[U_BITS-1:0];
   endfunction

   function automatic logic signed [EXT_W-1:0] popcount(input logic [INPUTS-1:0] v);
      logic signed [EXT_W-1:0] c;
      c = '0;
      for (int i = 0; i < INPUTS; i++) c = c + EXT_W'(v[i]);
      return c;
   endfunction

   logic                       accept;
   logic                       wr_ok;
   logic [INPUTS-1:0]          x_shift;
   logic [INPUTS-1:0]          w_sel_p0;
   logic signed [U_BITS-1:0]   u_cur_p0;
   logic signed [EXT_W-1:0]    pop_p0;
   logic signed [EXT_W-1:0]    leak_p0;
   logic signed [EXT_W-1:0]    pen_p0;
   logic signed [EXT_W-1:0]    pre_p0;
   logic signed [U_BITS-1:0]   u_new_p0;
   logic                       spike_p0;
   logic [N_NEURONS-1:0]       spikes_next_p0;

   assign in_ready = rst_n && (state == IDLE);
   assign accept   = in_valid && in_ready;
   // Input bytes take priority over weight writes, which only land between steps.
   assign wr_ok    = cfg_w_we && (state == IDLE) && (cnt == '0) && !accept;

   always_comb begin
      x_shift        = x << 8;
      x_shift[7:0]   = in_data;
      w_sel_p0       = w[idx * INPUTS +: INPUTS];
      u_cur_p0       = u[idx];
      pop_p0         = popcount(w_sel_p0 & x);
      leak_p0        = (cfg_shift == 3'd0) ? '0 : EXT_W'(u_cur_p0 >>> cfg_shift);
      pen_p0         = was_spike[idx] ? EXT_W'(cfg_theta) : '0;
      pre_p0         = EXT_W'(u_cur_p0) - leak_p0 + pop_p0 - pen_p0;
      u_new_p0       = sat_u(pre_p0);
      spike_p0       = (u_new_p0 >= cfg_theta);
      spikes_next_p0 = was_spike;
      spikes_next_p0[idx] = spike_p0;
   end

   // Compute stage boundary: one neuron's state committed per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         wptr       <= '0;
         idx        <= '0;
         x          <= '0;
         w          <= '0;
         for (int n = 0; n < N_NEURONS; n++) u[n] <= '0;
         was_spike  <= '0;
         out_valid  <= 1'b0;
         out_spikes <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  x <= x_shift;
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     idx   <= '0;
                     state <= COMPUTE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (wr_ok) begin
                  w[{wptr, 3'b000} +: 8] <= cfg_w_data;
                  wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
               end
            end
            COMPUTE: begin
               u[idx]         <= u_new_p0;
               was_spike[idx] <= spike_p0;
               if (idx == IDX_LAST) begin
                  state      <= OUTPUT;
                  out_valid  <= 1'b1;
                  out_spikes <= spikes_next_p0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Directed bench for lif_neuron_layer: integration, leak, saturation, backpressure and reset.
module tb_lif_neuron_layer;

   localparam int N  = 4;
   localparam int IN = 32;
   localparam int UB = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  cfg_w_we;
   logic [7:0]            cfg_w_data;
   logic [2:0]            cfg_shift;
   logic signed [UB-1:0]  cfg_theta;
   logic                  out_valid;
   logic [N-1:0]          out_spikes;
   logic                  out_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lif_neuron_layer #(.N_NEURONS(N), .INPUTS(IN), .U_BITS(UB)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .cfg_w_we(cfg_w_we), .cfg_w_data(cfg_w_data), .cfg_shift(cfg_shift), .cfg_theta(cfg_theta),
      .out_valid(out_valid), .out_spikes(out_spikes), .out_ready(out_ready)
   );

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; cfg_w_we = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_weights(input logic [127:0] pat);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         cfg_w_we = 1'b1; cfg_w_data = pat[8*k +: 8];
      end
      @(negedge clk);
      cfg_w_we = 1'b0;
   endtask

   task automatic run_step(input logic [7:0] b, input bit ack, output logic [N-1:0] spk, output int lat);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = b;
      end
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 40);
      spk = out_spikes;
      if (ack && out_valid) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; cfg_w_we = 1'b0; out_ready = 1'b0;
      in_data = 8'h00; cfg_w_data = 8'h00; cfg_shift = 3'd0; cfg_theta = 8'sd5;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_spikes !== 4'b0000) begin errors++; $display("FAIL reset_out_spikes: got %b expected 0000", out_spikes); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_integrate();
      logic [N-1:0] spk; int lat;
      do_reset();
      cfg_theta = 8'sd5; cfg_shift = 3'd0;
      load_weights({16{8'hFF}});
      run_step(8'hFF, 1'b1, spk, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL latency: got %0d expected 5", lat); end
      checks++; if (spk !== 4'b1111) begin errors++; $display("FAIL integ_spikes: got %b expected 1111", spk); end
      for (int n = 0; n < N; n++) begin
         checks++; if (dut.u[n] !== 8'sd32) begin errors++; $display("FAIL integ_u%0d: got %0d expected 32", n, dut.u[n]); end
      end
      run_step(8'h00, 1'b1, spk, lat);
      checks++; if (spk !== 4'b1111) begin errors++; $display("FAIL refractory_spikes: got %b expected 1111", spk); end
      for (int n = 0; n < N; n++) begin
         checks++; if (dut.u[n] !== 8'sd27) begin errors++; $display("FAIL refractory_u%0d: got %0d expected 27", n, dut.u[n]); end
      end
   endtask

   task automatic test_saturate();
      logic [N-1:0] spk; int lat;
      int exp_u [4] = '{32, 64, 96, 127};
      logic [N-1:0] exp_s [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
      do_reset();
      cfg_theta = 8'sd100; cfg_shift = 3'd0;
      load_weights({16{8'hFF}});
      for (int s = 0; s < 4; s++) begin
         run_step(8'hFF, 1'b1, spk, lat);
         checks++; if (spk !== exp_s[s]) begin errors++; $display("FAIL sat_spikes step%0d: got %b expected %b", s, spk, exp_s[s]); end
         for (int n = 0; n < N; n++) begin
            checks++; if (int'(dut.u[n]) !== exp_u[s]) begin errors++; $display("FAIL sat_u%0d step%0d: got %0d expected %0d", n, s, dut.u[n], exp_u[s]); end
         end
      end
   endtask

   task automatic test_leak();
      logic [N-1:0] spk; int lat;
      int exp_u [7] = '{32, 16, 8, 4, 2, 1, 1};
      do_reset();
      cfg_theta = 8'sd127; cfg_shift = 3'd1;
      load_weights({16{8'hFF}});
      for (int s = 0; s < 7; s++) begin
         run_step((s == 0) ? 8'hFF : 8'h00, 1'b1, spk, lat);
         checks++; if (spk !== 4'b0000) begin errors++; $display("FAIL leak_spikes step%0d: got %b expected 0000", s, spk); end
         for (int n = 0; n < N; n++) begin
            checks++; if (int'(dut.u[n]) !== exp_u[s]) begin errors++; $display("FAIL leak_u%0d step%0d: got %0d expected %0d", n, s, dut.u[n], exp_u[s]); end
         end
      end
      cfg_shift = 3'd0;
   endtask

   task automatic test_backpressure();
      logic [N-1:0] spk; int lat;
      do_reset();
      cfg_theta = 8'sd5; cfg_shift = 3'd0;
      load_weights({32'h0, 32'hFFFF_FFFF, 64'h0});
      run_step(8'hFF, 1'b0, spk, lat);
      checks++; if (spk !== 4'b0100) begin errors++; $display("FAIL bp_spikes: got %b expected 0100", spk); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d: got %b expected 1", c, out_valid); end
         checks++; if (out_spikes !== 4'b0100) begin errors++; $display("FAIL bp_hold cyc%0d: got %b expected 0100", c, out_spikes); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", c, in_ready); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      int wait_cyc;
      do_reset();
      cfg_theta = 8'sd5; cfg_shift = 3'd0;
      load_weights({16{8'hFF}});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'hFF;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
      for (int n = 0; n < N; n++) begin
         checks++; if (dut.u[n] !== 8'sd0) begin errors++; $display("FAIL midrst_u%0d: got %0d expected 0", n, dut.u[n]); end
      end
      checks++; if (dut.w !== '0) begin errors++; $display("FAIL midrst_weights: got %h expected 0", dut.w); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: got %b expected 1", in_ready); end
      // weight write colliding with an accepted input byte
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hFF; cfg_w_we = 1'b1; cfg_w_data = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      // weight write with a partial input vector pending
      @(negedge clk);
      cfg_w_we = 1'b0;
      checks++; if (dut.w !== '0) begin errors++; $display("FAIL wr_collide_weights: got %h expected 0", dut.w); end
      checks++; if (dut.wptr !== '0) begin errors++; $display("FAIL wr_collide_ptr: got %0d expected 0", dut.wptr); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'hFF;
      end
      wait_cyc = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         wait_cyc++;
      end while (!out_valid && wait_cyc < 40);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_w_timeout: got %b expected 1", out_valid); end
      checks++; if (out_spikes !== 4'b0000) begin errors++; $display("FAIL zero_w_spikes: got %b expected 0000", out_spikes); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_integrate();
      test_saturate();
      test_leak();
      test_backpressure();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
